// File: rtl/if_id_stall_pipe.sv
// Front-end pipeline storage: PC, IF/ID and the control half of ID/EX, steered by hazard controls.
// Optional STALL_COUNT_EN adds a saturating 32-bit count of stall (non-flush) cycles.
module if_id_stall_pipe #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    REG_NUMBER = 5,
    parameter int                    CTRL_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCWrite,
    input  logic                  IF_ID_Write,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [31:0]           imem_instr,
    input  logic [CTRL_WIDTH-1:0] ID_ctrl,
    input  logic [REG_NUMBER-1:0] ID_rd,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] IF_ID_pc,
    output logic [31:0]           IF_ID_instr,
    output logic                  IF_ID_valid,
    output logic [REG_NUMBER-1:0] IF_ID_rs1,
    output logic [REG_NUMBER-1:0] IF_ID_rs2,
    output logic [CTRL_WIDTH-1:0] ID_EX_ctrl,
    output logic                  ID_EX_MemRead,
    output logic [REG_NUMBER-1:0] ID_EX_rd,
    output logic                  ID_EX_valid
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]           if_id_instr_q, if_id_instr_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic [CTRL_WIDTH-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
    logic [REG_NUMBER-1:0] id_ex_rd_q, id_ex_rd_d;
    logic                  id_ex_valid_q, id_ex_valid_d;

    // Flush outranks every other control in all three stages.
    always_comb begin
        pc_d = pc_q;
        if (Flush) begin
            pc_d = branch_target;
        end else if (PCWrite) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (Flush) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (IF_ID_Write) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_instr;
            if_id_valid_d = 1'b1;
        end
    end

    always_comb begin
        id_ex_ctrl_d  = '0;
        id_ex_rd_d    = '0;
        id_ex_valid_d = 1'b0;
        if (!Flush && !Stall && if_id_valid_q) begin
            id_ex_ctrl_d  = ID_ctrl;
            id_ex_rd_d    = ID_rd;
            id_ex_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            id_ex_ctrl_q  <= '0;
            id_ex_rd_q    <= '0;
            id_ex_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_ctrl_q  <= id_ex_ctrl_d;
            id_ex_rd_q    <= id_ex_rd_d;
            id_ex_valid_q <= id_ex_valid_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (Stall && !Flush && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

    // Invalid IF/ID reports x0 sources so a bubble never raises a false hazard.
    assign IF_ID_rs1     = if_id_valid_q ? REG_NUMBER'(if_id_instr_q[19:15]) : '0;
    assign IF_ID_rs2     = if_id_valid_q ? REG_NUMBER'(if_id_instr_q[24:20]) : '0;

    assign pc            = pc_q;
    assign IF_ID_pc      = if_id_pc_q;
    assign IF_ID_instr   = if_id_instr_q;
    assign IF_ID_valid   = if_id_valid_q;
    assign ID_EX_ctrl    = id_ex_ctrl_q;
    assign ID_EX_MemRead = id_ex_ctrl_q[0];
    assign ID_EX_rd      = id_ex_rd_q;
    assign ID_EX_valid   = id_ex_valid_q;

endmodule

// File: tb/tb_if_id_stall_pipe.sv
// Bench for if_id_stall_pipe: two instances (RESET_PC 0 and 0xFFFFFFFC) share the control inputs.
// Expected states from a reference model go into exp_q; a monitor pops and compares after each edge.
module tb_if_id_stall_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] instr;
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic        exv;
    logic [31:0] sc;
  } m_t;
  localparam int M_W = $bits(m_t);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pcwrite = 1'b0, ifid_write = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [7:0] id_ctrl = '0;
  logic [4:0] id_rd = '0;
  logic [31:0] imem0, imem1;

  logic [31:0] o0_pc, o0_ifid_pc, o0_instr, o0_sc, o1_pc, o1_ifid_pc, o1_instr, o1_sc;
  logic o0_valid, o0_exv, o0_mr, o1_valid, o1_exv, o1_mr;
  logic [4:0] o0_rs1, o0_rs2, o0_rd, o1_rs1, o1_rs2, o1_rd;
  logic [7:0] o0_ctrl, o1_ctrl;

  logic [M_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  m_t m0, m1;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Instruction memory: arbitrary hash of the address so rs fields vary.
  function automatic logic [31:0] imem_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem0 = imem_of(o0_pc);
  assign imem1 = imem_of(o1_pc);

  if_id_stall_pipe #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(pcwrite), .IF_ID_Write(ifid_write),
    .Stall(stall), .Flush(flush), .branch_target(branch_target),
    .imem_instr(imem0), .ID_ctrl(id_ctrl), .ID_rd(id_rd),
    .pc(o0_pc), .IF_ID_pc(o0_ifid_pc), .IF_ID_instr(o0_instr), .IF_ID_valid(o0_valid),
    .IF_ID_rs1(o0_rs1), .IF_ID_rs2(o0_rs2), .ID_EX_ctrl(o0_ctrl), .ID_EX_MemRead(o0_mr),
    .ID_EX_rd(o0_rd), .ID_EX_valid(o0_exv)
`ifdef STALL_COUNT_EN
    , .stall_count(o0_sc)
`endif
  );

  if_id_stall_pipe #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .PCWrite(pcwrite), .IF_ID_Write(ifid_write),
    .Stall(stall), .Flush(flush), .branch_target(branch_target),
    .imem_instr(imem1), .ID_ctrl(id_ctrl), .ID_rd(id_rd),
    .pc(o1_pc), .IF_ID_pc(o1_ifid_pc), .IF_ID_instr(o1_instr), .IF_ID_valid(o1_valid),
    .IF_ID_rs1(o1_rs1), .IF_ID_rs2(o1_rs2), .ID_EX_ctrl(o1_ctrl), .ID_EX_MemRead(o1_mr),
    .ID_EX_rd(o1_rd), .ID_EX_valid(o1_exv)
`ifdef STALL_COUNT_EN
    , .stall_count(o1_sc)
`endif
  );

`ifndef STALL_COUNT_EN
  assign o0_sc = '0;
  assign o1_sc = '0;
`endif

  // ---------------- reference model ----------------
  function automatic m_t model_reset(logic [31:0] rpc);
    m_t s;
    s = '0;
    s.pc = rpc;
    s.instr = NOP;
    return s;
  endfunction

  function automatic m_t model_step(m_t s, logic pcw, logic ifw, logic st, logic fl,
                                    logic [31:0] tgt, logic [7:0] ctrl, logic [4:0] rd);
    m_t n;
    n = s;
    n.pc = fl ? tgt : (pcw ? s.pc + 32'd4 : s.pc);
    if (fl) begin
      n.valid = 1'b0;
      n.instr = NOP;
    end else if (ifw) begin
      n.ifid_pc = s.pc;
      n.instr = imem_of(s.pc);
      n.valid = 1'b1;
    end
    n.exv = !(fl || st) && s.valid;
    n.ctrl = n.exv ? ctrl : 8'h00;
    n.rd = n.exv ? rd : 5'd0;
    if (st && !fl && s.sc != 32'hFFFF_FFFF) n.sc = s.sc + 32'd1;
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic check_inst(int inst, m_t e, logic [31:0] a_pc, logic [31:0] a_ifid_pc,
                            logic [31:0] a_instr, logic a_valid, logic [4:0] a_rs1,
                            logic [4:0] a_rs2, logic [7:0] a_ctrl, logic a_mr,
                            logic [4:0] a_rd, logic a_exv, logic [31:0] a_sc);
    chk("pc", inst, a_pc, e.pc);
    if (e.valid) chk("IF_ID_pc", inst, a_ifid_pc, e.ifid_pc);
    chk("IF_ID_instr", inst, a_instr, e.instr);
    chk("IF_ID_valid", inst, 32'(a_valid), 32'(e.valid));
    chk("IF_ID_rs1", inst, 32'(a_rs1), e.valid ? 32'(e.instr[19:15]) : 32'd0);
    chk("IF_ID_rs2", inst, 32'(a_rs2), e.valid ? 32'(e.instr[24:20]) : 32'd0);
    chk("ID_EX_ctrl", inst, 32'(a_ctrl), 32'(e.ctrl));
    chk("ID_EX_MemRead", inst, 32'(a_mr), 32'(e.ctrl[0]));
    chk("ID_EX_rd", inst, 32'(a_rd), 32'(e.rd));
    chk("ID_EX_valid", inst, 32'(a_exv), 32'(e.exv));
`ifdef STALL_COUNT_EN
    chk("stall_count", inst, a_sc, e.sc);
`else
    if (a_sc !== 32'd0) chk("stall_count_tie", inst, a_sc, 32'd0);
`endif
  endtask

  // Monitor: two entries per edge, instance 0 first.
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() >= 2) begin
      m_t e0, e1;
      e0 = m_t'(exp_q.pop_front());
      e1 = m_t'(exp_q.pop_front());
      check_inst(0, e0, o0_pc, o0_ifid_pc, o0_instr, o0_valid, o0_rs1, o0_rs2,
                 o0_ctrl, o0_mr, o0_rd, o0_exv, o0_sc);
      check_inst(1, e1, o1_pc, o1_ifid_pc, o1_instr, o1_valid, o1_rs1, o1_rs2,
                 o1_ctrl, o1_mr, o1_rd, o1_exv, o1_sc);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic cycle(logic pcw, logic ifw, logic st, logic fl, logic [31:0] tgt);
    pcwrite = pcw;
    ifid_write = ifw;
    stall = st;
    flush = fl;
    branch_target = tgt;
    id_ctrl = 8'($urandom);
    id_rd = 5'($urandom);
    m0 = model_step(m0, pcw, ifw, st, fl, tgt, id_ctrl, id_rd);
    m1 = model_step(m1, pcw, ifw, st, fl, tgt, id_ctrl, id_rd);
    exp_q.push_back(M_W'(m0));
    exp_q.push_back(M_W'(m1));
    @(negedge clk);
  endtask

  task automatic do_reset();
    if (exp_q.size() != 0) chk("queue_drain_before_reset", 0, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", 0, o0_pc, 32'h0000_0000);
    chk("rst_pc", 1, o1_pc, 32'hFFFF_FFFC);
    chk("rst_IF_ID_pc", 0, o0_ifid_pc, 32'd0);
    chk("rst_IF_ID_instr", 0, o0_instr, NOP);
    chk("rst_IF_ID_valid", 0, 32'(o0_valid), 32'd0);
    chk("rst_IF_ID_rs1", 0, 32'(o0_rs1), 32'd0);
    chk("rst_IF_ID_rs2", 0, 32'(o0_rs2), 32'd0);
    chk("rst_ID_EX_ctrl", 0, 32'(o0_ctrl), 32'd0);
    chk("rst_ID_EX_rd", 0, 32'(o0_rd), 32'd0);
    chk("rst_ID_EX_valid", 0, 32'(o0_exv), 32'd0);
    chk("rst_stall_count", 0, o0_sc, 32'd0);
    m0 = model_reset(32'h0000_0000);
    m1 = model_reset(32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_cycles(int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // Free run, then a one-cycle load-use stall at pc=8, then resume.
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    // Flush over stall redirects to 0x40.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    // Decoupled controls: reload same pc, and stall with enables high.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    // Reset in the middle of a stall+flush, then stall counting.
    stall = 1'b1;
    flush = 1'b1;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
`ifdef STALL_COUNT_EN
    chk("stall_count_after_3", 0, o0_sc, 32'd3);
`endif

    random_cycles(2000);
    stall = 1'b1;
    do_reset();
    random_cycles(500);

    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drain_final", 0, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
